// File: rtl/pipe_pkg.sv
// Shared types and sizing helpers for the pipeline-stage skid buffer.
// State encoding doubles as the occupancy count.
package pipe_pkg;

    typedef enum logic [1:0] {
        PS_EMPTY = 2'd0,
        PS_BUSY  = 2'd1,
        PS_FULL  = 2'd2
    } pipe_state_t;

    localparam int PIPE_WIDTH = 32;
    localparam int PIPE_NCH   = 8;
    localparam int BUS_W      = PIPE_NCH * PIPE_WIDTH;

    function automatic int bus_w(input int nch, input int width);
        return nch * width;
    endfunction

endpackage

// File: rtl/pipe_data_reg.sv
// Data holding register with async reset to zero, synchronous clear and load enable.
// Clear has priority over load.
module pipe_data_reg #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_load,
    input  logic         i_clear,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_q;

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_q <= '0;
        end else if (i_clear) begin
            r_q <= '0;
        end else if (i_load) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/pipe_stage_buf.sv
// Two-entry skid buffer between CPU pipeline stages with registered valid/ready
// and a synchronous squash. main is always the head entry; skid holds the second.
module pipe_stage_buf
    import pipe_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int NCH        = 8,
    parameter bit CLEAR_DATA = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [NCH*WIDTH-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [NCH*WIDTH-1:0] out_data,
    output logic [1:0]           occupancy
);

    localparam int LP_BUS_W = bus_w(NCH, WIDTH);

    pipe_state_t         r_state;
    pipe_state_t         w_state_nxt;
    logic                w_accept;
    logic                w_emit;
    logic                w_main_load;
    logic                w_skid_load;
    logic                w_clear;
    logic [LP_BUS_W-1:0] w_main_d;
    logic [LP_BUS_W-1:0] w_main_q;
    logic [LP_BUS_W-1:0] w_skid_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= PS_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // NOTE: default assignment first keeps this block free of inferred latches.
    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = PS_EMPTY;
        end else begin
            case (r_state)
                PS_EMPTY: if (w_accept) w_state_nxt = PS_BUSY;
                PS_BUSY: begin
                    if (w_accept && !w_emit) begin
                        w_state_nxt = PS_FULL;
                    end else if (!w_accept && w_emit) begin
                        w_state_nxt = PS_EMPTY;
                    end
                end
                PS_FULL:  if (w_emit) w_state_nxt = PS_BUSY;
                default:  w_state_nxt = PS_EMPTY;
            endcase
        end
    end

    // Handshake outputs decode the state flops only, never out_ready.
    always_comb begin
        in_ready  = (r_state != PS_FULL);
        out_valid = (r_state != PS_EMPTY);
        case (r_state)
            PS_BUSY: occupancy = 2'd1;
            PS_FULL: occupancy = 2'd2;
            default: occupancy = 2'd0;
        endcase
    end

    assign w_accept = in_valid & in_ready;
    assign w_emit   = out_valid & out_ready;

    // Data loads only on the listed transitions; a squash blocks every load.
    assign w_main_load = !flush && (((r_state == PS_EMPTY) && w_accept) ||
                                    ((r_state == PS_BUSY) && w_accept && w_emit) ||
                                    ((r_state == PS_FULL) && w_emit));
    assign w_skid_load = !flush && (r_state == PS_BUSY) && w_accept && !w_emit;
    assign w_main_d    = (r_state == PS_FULL) ? w_skid_q : in_data;
    assign w_clear     = CLEAR_DATA ? flush : 1'b0;

    pipe_data_reg #(.W(LP_BUS_W)) u_main (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_main_load),
        .i_clear (w_clear),
        .i_d     (w_main_d),
        .o_q     (w_main_q)
    );

    pipe_data_reg #(.W(LP_BUS_W)) u_skid (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_skid_load),
        .i_clear (w_clear),
        .i_d     (in_data),
        .o_q     (w_skid_q)
    );

    assign out_data = w_main_q;

endmodule
